// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, runs the req/ready/rvalid fetch handshake and
// presents one instruction at a time. Optional opcode screening under FETCH_ILLEGAL_OP_EN.
module instr_fetch #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic            zero_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [6:0]      opcode_o,
    output logic [XLEN-1:0] pc_o,
`ifdef FETCH_ILLEGAL_OP_EN
    output logic            illegal_o,
`endif
    output logic [1:0]      fsm_state_o
);

    // Handshake: a request is granted on any cycle where imem_req & imem_ready; the single
    // outstanding response is accepted on the first imem_rvalid while waiting for it.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic            valid_q, valid_d;
`ifdef FETCH_ILLEGAL_OP_EN
    logic            illegal_q, illegal_d;
    logic            op_legal;

    always_comb begin
        op_legal = 1'b0;
        case (imem_rdata[6:0])
            7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011: op_legal = 1'b1;
            default:                                        op_legal = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            pc_out_q  <= RESET_PC;
            valid_q   <= 1'b0;
`ifdef FETCH_ILLEGAL_OP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
            valid_q   <= valid_d;
`ifdef FETCH_ILLEGAL_OP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        valid_d   = valid_q;
`ifdef FETCH_ILLEGAL_OP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    valid_d  = 1'b1;
                    pc_out_d = pc_q;
                    state_d  = S_HOLD;
`ifdef FETCH_ILLEGAL_OP_EN
                    // Unknown opcodes become an all-zero word so the decoder deasserts everything.
                    instr_d   = op_legal ? imem_rdata : '0;
                    illegal_d = ~op_legal;
`else
                    instr_d  = imem_rdata;
`endif
                end
            end
            S_HOLD: begin
                // Stall has priority; branch/zero are only acted on in the release cycle.
                if (!stall_i) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                    pc_d    = (branch_i && zero_i) ? {branch_target_i[XLEN-1:2], 2'b00}
                                                   : pc_q + PC_STEP;
`ifdef FETCH_ILLEGAL_OP_EN
                    illegal_d = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_req      = (state_q == S_REQ);
    assign imem_addr     = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign opcode_o      = instr_q[6:0];
    assign pc_o          = pc_out_q;
    assign fsm_state_o   = state_q;
`ifdef FETCH_ILLEGAL_OP_EN
    assign illegal_o     = illegal_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed reset/sequence/branch/wrap/abort cases, then randomized
// fetches with random handshake delays, stalls and branches against a PC/instruction model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_i;
  logic        branch_i;
  logic        zero_i;
  logic [31:0] branch_target_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [6:0]  opcode_o;
  logic [31:0] pc_o;
  logic [1:0]  fsm_state_o;
`ifdef FETCH_ILLEGAL_OP_EN
  logic        illegal_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: PC of the next fetch, and the instruction/PC currently expected on the outputs.
  logic [31:0] exp_pc;
  logic [31:0] held_instr;
  logic [31:0] held_pc;
  logic        held_illegal;
  logic [31:0] exp_q[$];

  instr_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .zero_i          (zero_i),
    .branch_target_i (branch_target_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .opcode_o        (opcode_o),
    .pc_o            (pc_o),
`ifdef FETCH_ILLEGAL_OP_EN
    .illegal_o       (illegal_o),
`endif
    .fsm_state_o     (fsm_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the negedge, away from the active edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [31:0] w);
    return (w[6:0] == 7'h33) || (w[6:0] == 7'h03) || (w[6:0] == 7'h23) || (w[6:0] == 7'h63);
  endfunction

  function automatic logic [31:0] model_instr(input logic [31:0] w);
`ifdef FETCH_ILLEGAL_OP_EN
    return is_legal(w) ? w : 32'h0;
`else
    return w;
`endif
  endfunction

  task automatic check_illegal(input string tag, input logic exp);
`ifdef FETCH_ILLEGAL_OP_EN
    check_eq(tag, {31'b0, illegal_o}, {31'b0, exp});
`endif
  endtask

  // ---------------- driver tasks ----------------
  // One fetch: REQ held for ready_dly cycles, grant, rvalid after rvalid_dly WAIT cycles.
  task automatic do_fetch(input logic [31:0] word, input int ready_dly, input int rvalid_dly);
    logic [31:0] exp_w;
    check_eq("req_asserted", {31'b0, imem_req}, 32'd1);
    check_eq("req_addr", imem_addr, exp_pc);
    for (int i = 0; i < ready_dly; i++) begin
      imem_ready  = 1'b0;
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom();
      tick();
      check_eq("req_held", {31'b0, imem_req}, 32'd1);
      check_eq("addr_held", imem_addr, exp_pc);
      check_eq("valid_in_req", {31'b0, instr_valid_o}, 32'd0);
    end
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    tick();
    imem_ready = 1'b0;
    check_eq("req_drop_after_grant", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < rvalid_dly; i++) begin
      tick();
      check_eq("valid_in_wait", {31'b0, instr_valid_o}, 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    exp_q.push_back(model_instr(word));
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    exp_w        = exp_q.pop_front();
    held_instr   = exp_w;
    held_pc      = exp_pc;
    held_illegal = ~is_legal(word);
    check_eq("instr_valid", {31'b0, instr_valid_o}, 32'd1);
    check_eq("instr", instr_o, exp_w);
    check_eq("opcode", {25'b0, opcode_o}, {25'b0, exp_w[6:0]});
    check_eq("pc_o", pc_o, exp_pc);
    check_eq("req_in_hold", {31'b0, imem_req}, 32'd0);
    check_illegal("illegal_set", held_illegal);
  endtask

  // HOLD phase: n_stall stalled cycles with noise on branch/zero/rvalid, then release.
  task automatic hold_phase(input int n_stall, input logic br, input logic zr,
                            input logic [31:0] tgt);
    for (int i = 0; i < n_stall; i++) begin
      stall_i         = 1'b1;
      branch_i        = 1'($urandom_range(0, 1));
      zero_i          = 1'($urandom_range(0, 1));
      branch_target_i = $urandom();
      imem_rvalid     = 1'($urandom_range(0, 1));
      imem_rdata      = $urandom();
      tick();
      check_eq("stall_instr", instr_o, held_instr);
      check_eq("stall_pc", pc_o, held_pc);
      check_eq("stall_valid", {31'b0, instr_valid_o}, 32'd1);
      check_eq("stall_req", {31'b0, imem_req}, 32'd0);
    end
    stall_i         = 1'b0;
    imem_rvalid     = 1'b0;
    branch_i        = br;
    zero_i          = zr;
    branch_target_i = tgt;
    tick();
    branch_i = 1'b0;
    zero_i   = 1'b0;
    if (br && zr) exp_pc = tgt & 32'hFFFF_FFFC;
    else          exp_pc = exp_pc + 32'd4;
    check_eq("release_valid", {31'b0, instr_valid_o}, 32'd0);
    check_eq("release_opcode", {25'b0, opcode_o}, {25'b0, held_instr[6:0]});
    check_eq("next_req", {31'b0, imem_req}, 32'd1);
    check_eq("next_addr", imem_addr, exp_pc);
    check_illegal("illegal_clear", 1'b0);
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    check_eq("rst_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_opcode", {25'b0, opcode_o}, 32'h0);
    check_eq("rst_pc_o", pc_o, 32'h0);
    check_illegal("rst_illegal", 1'b0);
    rst_n = 1'b1;
    tick();
    exp_pc = 32'h0;
    check_eq("rel_req", {31'b0, imem_req}, 32'd1);
    check_eq("rel_addr", imem_addr, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] word, r;
  int sel;

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    stall_i = 1'b0; branch_i = 1'b0; zero_i = 1'b0; branch_target_i = '0;
    exp_pc = '0; held_instr = '0; held_pc = '0; held_illegal = 1'b0;

    apply_reset(2);

    // Sequential pair, then a taken branch to a misaligned target, then a not-taken branch.
    do_fetch(32'h0000_0033, 0, 0);
    hold_phase(0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_2083, 0, 0);
    hold_phase(0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_0063, 0, 0);
    hold_phase(0, 1'b1, 1'b1, 32'h0000_0041);
    do_fetch(32'h0000_0063, 0, 0);
    hold_phase(0, 1'b1, 1'b0, 32'h0000_0041);

    // Backpressure and stall, then PC wrap from the top of the address space.
    do_fetch(32'h0000_0023, 3, 2);
    hold_phase(5, 1'b1, 1'b1, 32'hFFFF_FFFF);
    do_fetch(32'h0040_0033, 0, 0);
    hold_phase(0, 1'b0, 1'b1, 32'h1234_5678);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // Illegal opcode followed by a legal one.
    do_fetch(32'h0000_007F, 1, 0);
    hold_phase(1, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_0003, 0, 1);
    hold_phase(0, 1'b0, 1'b0, 32'h0);

    // Reset while a response is outstanding aborts the transfer.
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    apply_reset(1);

    for (int t = 0; t < 60; t++) begin
      r   = $urandom();
      sel = $urandom_range(0, 5);
      case (sel)
        0: word = {r[31:7], 7'h33};
        1: word = {r[31:7], 7'h03};
        2: word = {r[31:7], 7'h23};
        3: word = {r[31:7], 7'h63};
        default: word = r;
      endcase
      do_fetch(word, $urandom_range(0, 3), $urandom_range(0, 3));
      hold_phase($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
